// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and IDLE/ACCESS/RESP sequencer for a single-cycle data memory.
// Optional feature: define DMEM_ARB_BOUNDS_CHECK_EN to reject accesses that run past MEM_BYTES.
module dmem_arbiter #(
    parameter int ADDR_W    = 64,
    parameter int DATA_W    = 64,
    parameter int MEM_BYTES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] write_data,
    output logic              memWrite,
    output logic              memRead,
    input  logic [DATA_W-1:0] read_data
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]        state;
    logic              last_grant;
    logic              grant_q;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic grant_sel;
    logic accept;
    logic in_access;
    logic in_resp;
    logic oob;
    logic issue;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    logic [ADDR_W:0] last_byte;
    always_comb begin
        // One extra bit so addresses near the top of the space cannot wrap past the limit.
        last_byte = {1'b0, lat_addr} + (ADDR_W+1)'(7);
        oob       = (last_byte >= (ADDR_W+1)'(MEM_BYTES));
    end
`else
    assign oob = 1'b0;
`endif

    // NOTE: every output is gated by !reset so the block is quiet during reset even though
    // state only clears on the next edge; this also keeps a store in ACCESS from committing.
    always_comb begin
        grant_sel  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        accept     = (state == IDLE) && (req0_valid || req1_valid) && !reset;
        req0_ready = accept && !grant_sel;
        req1_ready = accept &&  grant_sel;

        in_access   = (state == ACCESS) && !reset;
        issue       = in_access && !oob;
        mem_address = in_access ? lat_addr  : '0;
        write_data  = in_access ? lat_wdata : '0;
        memWrite    = issue &&  lat_write;
        memRead     = issue && !lat_write;

        in_resp    = (state == RESP) && !reset;
        rsp0_valid = in_resp && !grant_q;
        rsp1_valid = in_resp &&  grant_q;
        rsp0_rdata = rsp0_valid ? rdata_q : '0;
        rsp1_rdata = rsp1_valid ? rdata_q : '0;
        rsp0_err   = rsp0_valid && err_q;
        rsp1_err   = rsp1_valid && err_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_q    <= 1'b0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        grant_q    <= grant_sel;
                        last_grant <= grant_sel;
                        lat_write  <= grant_sel ? req1_write : req0_write;
                        lat_addr   <= grant_sel ? req1_addr  : req0_addr;
                        lat_wdata  <= grant_sel ? req1_wdata : req0_wdata;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    rdata_q <= (issue && !lat_write) ? read_data : '0;
                    err_q   <= oob;
                    state   <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: byte-addressed memory model, scoreboard of accepted
// requests compared against responses, and directed steps for each scenario.
module tb_dmem_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int MB = 64;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          req0_valid, req0_write, req0_ready, rsp0_valid, rsp0_err;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, rsp0_rdata;
    logic          req1_valid, req1_write, req1_ready, rsp1_valid, rsp1_err;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, rsp1_rdata;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] write_data, read_data;
    logic          memWrite, memRead;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_BYTES(MB)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
        .mem_address(mem_address), .write_data(write_data),
        .memWrite(memWrite), .memRead(memRead), .read_data(read_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory seen by the DUT and the bench's reference copy of its contents.
    logic [63:0] pattern = 64'h009A84B30F053434;
    logic [7:0]  mem     [MB];
    logic [7:0]  ref_mem [MB];
    logic        mem_load = 1'b1;
    int          cyc = 0;

    always_comb begin
        read_data = '0;
        for (int k = 0; k < 8; k++)
            if (mem_address + 64'(k) < 64'(MB))
                read_data[8*k +: 8] = mem[int'(mem_address) + k];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_load) begin
            for (int i = 0; i < MB; i++) mem[i] <= pattern[8*(i%8) +: 8];
        end else if (memWrite) begin
            for (int k = 0; k < 8; k++)
                if (mem_address + 64'(k) < 64'(MB))
                    mem[int'(mem_address) + k] <= write_data[8*k +: 8];
        end
    end

    function automatic logic [63:0] ref_read(input logic [63:0] a);
        logic [63:0] r = '0;
        for (int k = 0; k < 8; k++)
            if (a + 64'(k) < 64'(MB)) r[8*k +: 8] = ref_mem[int'(a) + k];
        return r;
    endfunction

    typedef struct {
        logic        port;
        logic        write;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          acc_cyc;
    } txn_t;

    txn_t        sb[$];
    logic        grant_log[$];
    int          grant_cyc[$];
    int          n_rd = 0, n_wr = 0, n_rsp = 0;
    logic [63:0] last_rdata = '0;
    logic        last_err = 1'b0;

    // Monitor: push on accept, pop and compare on response.
    always @(negedge clk) begin
        if (!reset) begin
            txn_t        t;
            logic        exp_err;
            logic [63:0] exp_rdata, obs_rdata, oth_rdata;
            logic        obs_err, oth_err;
            if (memRead)  n_rd++;
            if (memWrite) n_wr++;
            check("ready_onehot", {63'd0, req0_ready & req1_ready}, 64'd0);
            if (req0_ready || req1_ready) begin
                t.port    = req1_ready;
                t.write   = req1_ready ? req1_write : req0_write;
                t.addr    = req1_ready ? req1_addr  : req0_addr;
                t.wdata   = req1_ready ? req1_wdata : req0_wdata;
                t.acc_cyc = cyc;
                sb.push_back(t);
                grant_log.push_back(t.port);
                grant_cyc.push_back(cyc);
            end
            if (rsp0_valid || rsp1_valid) begin
                n_rsp++;
                if (sb.size() == 0) begin
                    check("rsp_unexpected", 64'd1, 64'd0);
                end else begin
                    t = sb.pop_front();
                    exp_err   = BOUNDS && (({1'b0, t.addr} + 65'd7) >= 65'(MB));
                    exp_rdata = (t.write || exp_err) ? 64'd0 : ref_read(t.addr);
                    if (t.write && !exp_err)
                        for (int k = 0; k < 8; k++)
                            if (t.addr + 64'(k) < 64'(MB)) ref_mem[int'(t.addr) + k] = t.wdata[8*k +: 8];
                    obs_rdata = t.port ? rsp1_rdata : rsp0_rdata;
                    obs_err   = t.port ? rsp1_err   : rsp0_err;
                    oth_rdata = t.port ? rsp0_rdata : rsp1_rdata;
                    oth_err   = t.port ? rsp0_err   : rsp1_err;
                    check("rsp_port", {62'd0, rsp1_valid, rsp0_valid}, t.port ? 64'd2 : 64'd1);
                    check("rsp_rdata", obs_rdata, exp_rdata);
                    check("rsp_err", {63'd0, obs_err}, {63'd0, exp_err});
                    check("rsp_other_port_quiet", oth_rdata | {63'd0, oth_err}, 64'd0);
                    check("rsp_latency", 64'(cyc - t.acc_cyc), 64'd2);
                    check("rsp_mem_bus_idle", mem_address | write_data | {62'd0, memWrite, memRead}, 64'd0);
                    last_rdata = obs_rdata;
                    last_err   = obs_err;
                end
            end
        end
    end

    task automatic do_req(input logic p, input logic w, input logic [63:0] a, input logic [63:0] d);
        bit got = 1'b0;
        @(posedge clk); #1;
        if (p) begin req1_valid = 1'b1; req1_write = w; req1_addr = a; req1_wdata = d; end
        else   begin req0_valid = 1'b1; req0_write = w; req0_addr = a; req0_wdata = d; end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p ? req1_ready : req0_ready) begin got = 1'b1; break; end
        end
        check("req_accept_timeout", {63'd0, got}, 64'd1);
        @(posedge clk); #1;
        if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk); #1;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          rd0, wr0, nr, L, n0, n1;
        logic        g0, g1;
        reset = 1'b1;
        for (int i = 0; i < MB; i++) ref_mem[i] = pattern[8*(i%8) +: 8];
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 64'd8; req1_wdata = 64'hFFFF;

        // Reset state with both requests pending.
        repeat (3) @(negedge clk);
        check("reset_ctrl", {56'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                             rsp0_err, rsp1_err, memWrite, memRead}, 64'd0);
        check("reset_rdata", rsp0_rdata | rsp1_rdata, 64'd0);
        check("reset_mem_bus", mem_address | write_data, 64'd0);

        // Port 0 load from addr 0 right out of reset.
        @(posedge clk); #1;
        mem_load = 1'b0; req1_valid = 1'b0; reset = 1'b0;
        @(negedge clk);
        check("t1_ready0_cycle1", {62'd0, req0_ready, req1_ready}, 64'd2);
        @(posedge clk); #1; req0_valid = 1'b0;
        @(negedge clk);
        check("t1_memread_cycle2", {62'd0, memRead, memWrite}, 64'd2);
        check("t1_mem_address", mem_address, 64'd0);
        @(negedge clk);
        check("t1_rsp0_cycle3", {62'd0, rsp1_valid, rsp0_valid}, 64'd1);
        check("t1_rsp0_rdata", rsp0_rdata, 64'h009A84B30F053434);
        wait_done();

        // Port 1 store then load at addr 8.
        wr0 = n_wr;
        do_req(1'b1, 1'b1, 64'd8, 64'h1122334455667788);
        wait_done();
        check("t2_memwrite_cycles", 64'(n_wr - wr0), 64'd1);
        do_req(1'b1, 1'b0, 64'd8, 64'd0);
        wait_done();
        check("t2_load_back", last_rdata, 64'h1122334455667788);

        // Reset during the ACCESS cycle of a store to addr 16.
        do_req(1'b0, 1'b1, 64'd16, 64'hDEADBEEFCAFEF00D);
        reset = 1'b1;
        @(negedge clk);
        check("t3_memwrite_gated", {63'd0, memWrite}, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        nr = n_rsp;
        repeat (4) @(negedge clk);
        check("t3_no_response", 64'(n_rsp - nr), 64'd0);
        do_req(1'b0, 1'b0, 64'd16, 64'd0);
        wait_done();
        check("t3_store_not_committed", last_rdata, 64'h009A84B30F053434);

        // Load from addr 60: past the end of the memory.
        rd0 = n_rd;
        do_req(1'b1, 1'b0, 64'd60, 64'd0);
        wait_done();
        check("t5_err", {63'd0, last_err}, {63'd0, BOUNDS});
        check("t5_rdata", last_rdata, BOUNDS ? 64'd0 : 64'h00000000009A84B3);
        check("t5_memread_cycles", 64'(n_rd - rd0), BOUNDS ? 64'd0 : 64'd1);

        // Both ports requesting continuously, 4 requests each.
        L  = grant_log.size();
        n0 = 0; n1 = 0;
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 64'd24;
        req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 64'd24; req1_wdata = 64'hA5A5000000000000;
        for (int c = 0; c < 60 && (n0 < 4 || n1 < 4); c++) begin
            @(negedge clk);
            g0 = req0_ready; g1 = req1_ready;
            @(posedge clk); #1;
            if (g0) begin
                n0++;
                if (n0 < 4) req0_addr = 64'(24 + 8*n0); else req0_valid = 1'b0;
            end
            if (g1) begin
                n1++;
                if (n1 < 4) begin
                    req1_addr  = 64'(24 + 8*n1);
                    req1_wdata = 64'hA5A5000000000000 | 64'(n1);
                end else req1_valid = 1'b0;
            end
        end
        check("t4_grants_done", 64'(n0 + n1), 64'd8);
        wait_done();
        for (int k = 0; k < 8 && L + k < grant_log.size(); k++)
            check("t4_grant_order", {63'd0, grant_log[L+k]}, 64'(k % 2));
        for (int k = 0; k < 7 && L + k + 1 < grant_cyc.size(); k++)
            check("t4_grant_spacing", 64'(grant_cyc[L+k+1] - grant_cyc[L+k]), 64'd3);

        repeat (3) @(negedge clk);
        check("final_sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
